// File: rtl/tl_cntr_timed_if.sv
// Signal bundle between the traffic-light controller and its environment:
// car sensors in, lamp codes plus state/timer monitoring out.
interface tl_cntr_timed_if #(
   parameter int CNT_W = 5
);
   logic             ta;
   logic             tb;
   logic [1:0]       la;
   logic [1:0]       lb;
   logic [1:0]       state;
   logic [CNT_W-1:0] timer;

   modport master (
      output ta,
      output tb,
      input  la,
      input  lb,
      input  state,
      input  timer
   );

   modport slave (
      input  ta,
      input  tb,
      output la,
      output lb,
      output state,
      output timer
   );
endinterface

// File: rtl/tl_cntr_timed.sv
// Timed Moore traffic-light controller: sensor-driven min/max green dwell,
// fixed yellow dwell, lamps decoded from the registered state only.
module tl_cntr_timed #(
   parameter int GREEN_MIN = 5,
   parameter int GREEN_MAX = 20,
   parameter int YELLOW    = 3,
   parameter int CNT_W     = 5
) (
   input  logic            clk,
   input  logic            reset,
   tl_cntr_timed_if.slave  bus
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_e;

   localparam logic [1:0] LIGHT_GREEN  = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_RED    = 2'b10;

   // Last timer value of each dwell; exits are compared against these.
   localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW - 1);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] timer_q;
   logic [CNT_W-1:0] timer_d;
   logic             greenMinDone;
   logic             greenMaxDone;
   logic             yellowDone;
   logic [1:0]       lightA;
   logic [1:0]       lightB;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   assign greenMinDone = (timer_q >= GREEN_MIN_LAST);
   assign greenMaxDone = (timer_q == GREEN_MAX_LAST);
   assign yellowDone   = (timer_q == YELLOW_LAST);

   // A green phase ends once the minimum is served and its own road is empty,
   // or unconditionally at the maximum; the cross road's sensor is never used.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      unique case (state_q)
         S0: begin
            if ((greenMinDone && !bus.ta) || greenMaxDone) begin
               state_d = S1;
               timer_d = '0;
            end
         end
         S1: begin
            if (yellowDone) begin
               state_d = S2;
               timer_d = '0;
            end
         end
         S2: begin
            if ((greenMinDone && !bus.tb) || greenMaxDone) begin
               state_d = S3;
               timer_d = '0;
            end
         end
         S3: begin
            if (yellowDone) begin
               state_d = S0;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S0;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      lightA = LIGHT_RED;
      lightB = LIGHT_RED;
      unique case (state_q)
         S0:      lightA = LIGHT_GREEN;
         S1:      lightA = LIGHT_YELLOW;
         S2:      lightB = LIGHT_GREEN;
         S3:      lightB = LIGHT_YELLOW;
         default: begin
            lightA = LIGHT_RED;
            lightB = LIGHT_RED;
         end
      endcase
   end

   assign bus.la    = lightA;
   assign bus.lb    = lightB;
   assign bus.state = state_q;
   assign bus.timer = timer_q;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// Scoreboard bench for tl_cntr_timed: default instance on directed phase
// sequences plus a fixed-green (4/4/1) instance fed random sensors.
module tb_tl_cntr_timed;

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

   typedef struct {
      logic [1:0] st;
      int         tmr;
      logic [1:0] la;
      logic [1:0] lb;
   } exp_t;

   logic clk;
   logic reset;
   int   testsRun;
   int   testsFailed;
   int   pos2;
   logic started2;
   exp_t expQ[$];
   exp_t expQ2[$];

   tl_cntr_timed_if #(.CNT_W(5)) bus1 ();
   tl_cntr_timed_if #(.CNT_W(5)) bus2 ();

   tl_cntr_timed dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   tl_cntr_timed #(
      .GREEN_MIN (4),
      .GREEN_MAX (4),
      .YELLOW    (1),
      .CNT_W     (5)
   ) dutFixed (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   // Free-running clock: posedge at 5, 15, ...; inputs change on negedges.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] laOf(input logic [1:0] st);
      case (st)
         S0:      return 2'b00;
         S1:      return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [1:0] lbOf(input logic [1:0] st);
      case (st)
         S2:      return 2'b00;
         S3:      return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   // Drives one edge's inputs and queues what each DUT must show after it.
   task automatic applyStimulus(input logic rstV, input logic taV, input logic tbV,
                                input logic [1:0] st, input int tmr);
      exp_t e;
      exp_t e2;
      @(negedge clk);
      reset   = rstV;
      bus1.ta = taV;
      bus1.tb = tbV;
      bus2.ta = 1'($urandom_range(0, 1));
      bus2.tb = 1'($urandom_range(0, 1));
      e.st = st; e.tmr = tmr; e.la = laOf(st); e.lb = lbOf(st);
      expQ.push_back(e);
      if (rstV) begin
         pos2     = 0;
         started2 = 1'b1;
      end else begin
         pos2 = (pos2 + 1) % 10;
      end
      if (started2) begin
         if (pos2 < 4)       begin e2.st = S0; e2.tmr = pos2;     end
         else if (pos2 == 4) begin e2.st = S1; e2.tmr = 0;        end
         else if (pos2 < 9)  begin e2.st = S2; e2.tmr = pos2 - 5; end
         else                begin e2.st = S3; e2.tmr = 0;        end
         e2.la = laOf(e2.st);
         e2.lb = lbOf(e2.st);
         expQ2.push_back(e2);
      end
   endtask

   task automatic runPhase(input logic [1:0] st, input int first, input int last,
                           input logic taV, input logic tbV);
      for (int i = first; i <= last; i++) applyStimulus(1'b0, taV, tbV, st, i);
   endtask

   task automatic checkOutput(input string name, input exp_t e,
                              input logic [1:0] st, input logic [4:0] tmr,
                              input logic [1:0] la, input logic [1:0] lb);
      testsRun++;
      if (st !== e.st || tmr !== 5'(e.tmr) || la !== e.la || lb !== e.lb) begin
         testsFailed++;
         $display("[TB] FAIL %s @%0t: got state=%b timer=%0d la=%b lb=%b, want state=%b timer=%0d la=%b lb=%b",
                  name, $time, st, tmr, la, lb, e.st, e.tmr, e.la, e.lb);
      end
   endtask

   // Monitor: one sample per cycle, 1 time unit after the active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("dflt", e, bus1.state, bus1.timer, bus1.la, bus1.lb);
         end
         if (expQ2.size() > 0) begin
            e = expQ2.pop_front();
            checkOutput("fixed", e, bus2.state, bus2.timer, bus2.la, bus2.lb);
         end
      end
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      pos2        = 0;
      started2    = 1'b0;
      reset       = 1'b1;
      bus1.ta     = 1'b0;
      bus1.tb     = 1'b0;
      bus2.ta     = 1'b0;
      bus2.tb     = 1'b0;

      // Reset, then no demand: S0x5, S1x3, S2x5, S3x3, twice.
      applyStimulus(1'b1, 1'b0, 1'b0, S0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, S0, 0);
      runPhase(S0, 1, 4, 1'b0, 1'b0);
      runPhase(S1, 0, 2, 1'b0, 1'b0);
      runPhase(S2, 0, 4, 1'b0, 1'b0);
      runPhase(S3, 0, 2, 1'b0, 1'b0);
      runPhase(S0, 0, 4, 1'b0, 1'b0);
      runPhase(S1, 0, 2, 1'b0, 1'b0);
      runPhase(S2, 0, 4, 1'b0, 1'b0);
      runPhase(S3, 0, 2, 1'b0, 1'b0);

      // Constant demand on both roads: greens run to the 20-cycle maximum.
      runPhase(S0, 0, 19, 1'b1, 1'b1);
      runPhase(S1, 0, 2,  1'b1, 1'b1);
      runPhase(S2, 0, 19, 1'b1, 1'b1);
      runPhase(S3, 0, 2,  1'b1, 1'b1);

      // ta drops while timer=11: S0 lasts 12 cycles.
      runPhase(S0, 0, 11, 1'b1, 1'b1);
      runPhase(S1, 0, 2,  1'b0, 1'b1);
      runPhase(S2, 0, 19, 1'b0, 1'b1);
      runPhase(S3, 0, 2,  1'b0, 1'b1);

      // ta pulsed low at timer=2 is ignored: S0 still lasts 20 cycles.
      runPhase(S0, 0, 2, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, S0, 3);
      runPhase(S0, 4, 19, 1'b1, 1'b1);
      runPhase(S1, 0, 1,  1'b1, 1'b1);

      // Reset for two cycles mid-yellow, then the full 5-cycle minimum green.
      applyStimulus(1'b1, 1'b1, 1'b1, S0, 0);
      applyStimulus(1'b1, 1'b1, 1'b1, S0, 0);
      runPhase(S0, 1, 4, 1'b0, 1'b0);
      runPhase(S1, 0, 2, 1'b0, 1'b0);
      runPhase(S2, 0, 4, 1'b0, 1'b0);
      runPhase(S3, 0, 2, 1'b0, 1'b0);

      // Drain: let the monitor consume everything still queued.
      for (int i = 0; i < 4; i++) @(negedge clk);
      testsRun++;
      if (expQ.size() != 0 || expQ2.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d/%0d entries left, want 0/0", expQ.size(), expQ2.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
